data_mem_mmio: RTL
==================

Name: data_mem_mmio

Overview:
- Responder end of the core's data-memory port.
- Serves loads and stores issued in the MEM stage (ena_rd/ena_wr, address, write data), returning read data in the same cycle.
- Decodes the address into two regions: a word RAM, and a small peripheral page. The page holds a GPIO output register, a synchronised GPIO input and a prescaled timer with compare/interrupt flag.
- Sits beside the core at top level, in place of a plain data RAM.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth = 2**RAM_AW words of 32 bits).
- GPIO_W, 8, width of GPIO input and output buses.
- PRESC_W, 8, width of the timer prescaler register.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- ena_rd  in  1  load request, valid for one MEM cycle.
- ena_wr  in  1  store request, valid for one MEM cycle.
- addr  in  32  byte address from the ALU result.
- wdata  in  32  store data.
- rdata  out  32  load data, combinational from addr in the same cycle.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  GPIO output register.
- irq_timer  out  1  timer flag level (registered).

Behaviour:
- Address decode:
  - addr[1:0] ignored; all accesses are 32-bit words.
  - Region RAM: addr[31:28]==4'h0. Word index = addr[RAM_AW+1:2]; higher bits aliased.
  - Region PERIPH: addr[31:28]==4'h1. Register selected by addr[4:2]:
    - 0 GPIO_OUT: rw.
    - 1 GPIO_IN: ro.
    - 2 TIM_CNT: rw.
    - 3 TIM_CMP: rw.
    - 4 TIM_CTRL: bit0 EN rw, bit1 FLAG rw1c, bits[PRESC_W+7:8] PRESC rw.
    - 5..7 reserved: read 0, writes ignored.
  - Any other region: read 0, writes ignored.
- Reads:
  - rdata is combinational from addr and current state (zero added latency); the core registers it at the end of MEM.
  - rdata = 0 when ena_rd==0.
  - Narrow registers are zero-extended.
- Writes:
  - Take effect at the rising edge where ena_wr==1.
  - ena_rd and ena_wr both high on the same address: rdata shows the old value; the new value is visible from the next cycle.
- RAM:
  - Inferred synchronous-write, asynchronous-read array.
  - Contents not reset; power-up contents undefined.
- GPIO:
  - gpio_in passes through a 2-flop synchroniser. GPIO_IN reads the second flop, so latency is 2 edges.
  - gpio_out = GPIO_OUT register.
- Timer:
  - Prescale counter pcnt (PRESC_W bits). While EN: pcnt increments each cycle; when pcnt==PRESC it wraps to 0 and TIM_CNT increments. Tick period = PRESC+1 cycles; PRESC=0 gives 1 cycle.
  - TIM_CNT wraps 0xFFFFFFFF -> 0.
  - EN=0: pcnt and TIM_CNT hold.
  - Writing TIM_CTRL clears pcnt.
  - A TIM_CNT write in the same cycle as a tick: the written value wins; no increment.
  - FLAG set at the edge where a tick makes the new TIM_CNT equal TIM_CMP. It stays set until software writes 1 to bit1.
  - Set and clear in the same cycle: set wins.
  - irq_timer = FLAG.
- Reset (asynchronous, any time, including mid-access):
  - rdata follows inputs (0 with ena_rd=0).
  - gpio_out=0, irq_timer=0.
  - GPIO_OUT, TIM_CNT, TIM_CMP, TIM_CTRL, pcnt and synchroniser flops = 0.
  - A store coincident with reset assertion is lost.

Decomposition:
- Package data_mem_mmio_pkg holds:
  - region constants REG_RAM=4'h0, REG_PERIPH=4'h1;
  - register-offset enum periph_reg_e {GPIO_OUT, GPIO_IN, TIM_CNT, TIM_CMP, TIM_CTRL};
  - TIM_CTRL bit positions.
- One sub-module, mmio_timer: prescaler, counter, compare and flag, with write strobes in and read values out. RAM and decode stay in the top.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> rdata=0xDEADBEEF in the load cycle. Load 0x0000_0013 -> same value (low bits ignored).
- Simultaneous ena_wr=1, ena_rd=1 at 0x0000_0020, old value 0x1, wdata=0x2 -> rdata=0x1 that cycle; the next-cycle load returns 0x2. A load from 0x2000_0000 returns 0; a store there leaves RAM and the registers unchanged.
- Store 0xA5 to GPIO_OUT (0x1000_0000) -> gpio_out=0xA5 after the edge. Drive gpio_in=0x3C -> a GPIO_IN load (0x1000_0004) reads 0x3C starting 2 edges later, not before.
- TIM_CMP=5, TIM_CTRL=EN|PRESC=2 -> TIM_CNT increments every 3 cycles; FLAG/irq_timer rises on the edge where TIM_CNT becomes 5 (15 cycles after the enabling write). Write TIM_CTRL=0x1|0x2|PRESC=2 -> FLAG clears, EN stays set.
- Write TIM_CNT=0xFFFFFFFF with PRESC=0, EN=1 -> the next cycle reads 0x0 (wrap). A TIM_CNT write coincident with a tick loads the written value exactly.
- Assert RST_n=0 mid-count with FLAG=1 and gpio_out=0xFF -> gpio_out and irq_timer drop to 0 immediately (asynchronous); after release, all peripheral registers read 0.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO responder: region codes,
// peripheral register offsets and timer control bit positions.
package data_mem_mmio_pkg;

  localparam logic [3:0] REG_RAM    = 4'h0;
  localparam logic [3:0] REG_PERIPH = 4'h1;

  // Word offset of each register inside the peripheral page (addr[4:2]).
  typedef enum logic [2:0] {
    GPIO_OUT = 3'd0,
    GPIO_IN  = 3'd1,
    TIM_CNT  = 3'd2,
    TIM_CMP  = 3'd3,
    TIM_CTRL = 3'd4
  } periph_reg_e;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLAG_BIT  = 1;
  localparam int CTRL_PRESC_LSB = 8;

endpackage

// File: rtl/data_mem_mmio_timer.sv
// Prescaled 32-bit timer with compare match flag. The decode in the top
// hands over one write strobe per register plus the store data.
module mmio_timer
  import data_mem_mmio_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic [31:0] ctrl_rd,
  output logic        flag
);

  logic               en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic               match_set;
  logic               flag_clr;

  assign tick      = en && (pcnt == presc);
  assign match_set = tick && !cnt_we && ((cnt + 32'd1) == cmp);
  assign flag_clr  = ctrl_we && wdata[CTRL_FLAG_BIT];

  // Assemble the control register view; unused bits read as zero.
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN_BIT]   = en;
    ctrl_rd[CTRL_FLAG_BIT] = flag;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = presc;
  end

  // Prescaler: counts up to presc then wraps; a control write restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (ctrl_we) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt == presc) ? '0 : pcnt + 1'b1;
    end
  end

  // Main counter: a software write beats a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_we) begin
      cnt <= wdata;
    end else if (tick) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Compare value and control fields (enable, prescale).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp   <= '0;
      en    <= 1'b0;
      presc <= '0;
    end else begin
      if (cmp_we) cmp <= wdata;
      if (ctrl_we) begin
        en    <= wdata[CTRL_EN_BIT];
        presc <= wdata[CTRL_PRESC_LSB +: PRESC_W];
      end
    end
  end

  // Match flag: set on the tick that lands on cmp, write-1-to-clear, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (match_set) begin
      flag <= 1'b1;
    end else if (flag_clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-memory port responder: word RAM plus a peripheral page holding
// GPIO and a timer. Loads return data combinationally in the MEM cycle.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int GPIO_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              ena_rd,
  input  logic              ena_wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq_timer
);

  logic [31:0]       mem [2**RAM_AW];
  logic [RAM_AW-1:0] word_idx;
  logic              in_ram;
  logic              in_periph;
  logic [2:0]        reg_sel;
  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic              cnt_we;
  logic              cmp_we;
  logic              ctrl_we;
  logic [31:0]       tim_cnt;
  logic [31:0]       tim_cmp;
  logic [31:0]       tim_ctrl;
  logic              tim_flag;
  logic              unused_addr;

  // Byte offset and aliased upper bits carry no meaning for word accesses.
  assign unused_addr = ^{addr[1:0], addr[27:RAM_AW+2]};

  assign word_idx  = addr[RAM_AW+1:2];
  assign in_ram    = (addr[31:28] == REG_RAM);
  assign in_periph = (addr[31:28] == REG_PERIPH);
  assign reg_sel   = addr[4:2];

  assign cnt_we  = ena_wr && in_periph && (reg_sel == TIM_CNT);
  assign cmp_we  = ena_wr && in_periph && (reg_sel == TIM_CMP);
  assign ctrl_we = ena_wr && in_periph && (reg_sel == TIM_CTRL);

  assign gpio_out  = gpio_out_q;
  assign irq_timer = tim_flag;

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge CLOCK) begin
    if (ena_wr && in_ram && RST_n) begin
      mem[word_idx] <= wdata;
    end
  end

  // GPIO output register.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      gpio_out_q <= '0;
    end else if (ena_wr && in_periph && (reg_sel == GPIO_OUT)) begin
      gpio_out_q <= wdata[GPIO_W-1:0];
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  mmio_timer #(.PRESC_W(PRESC_W)) u_timer (
    .clk     (CLOCK),
    .rst_n   (RST_n),
    .cnt_we  (cnt_we),
    .cmp_we  (cmp_we),
    .ctrl_we (ctrl_we),
    .wdata   (wdata),
    .cnt     (tim_cnt),
    .cmp     (tim_cmp),
    .ctrl_rd (tim_ctrl),
    .flag    (tim_flag)
  );

  // Read mux: zero unless a load hits RAM or a defined peripheral register.
  always_comb begin
    rdata = '0;
    if (ena_rd) begin
      if (in_ram) begin
        rdata = mem[word_idx];
      end else if (in_periph) begin
        case (reg_sel)
          GPIO_OUT: rdata = {{(32-GPIO_W){1'b0}}, gpio_out_q};
          GPIO_IN:  rdata = {{(32-GPIO_W){1'b0}}, sync2};
          TIM_CNT:  rdata = tim_cnt;
          TIM_CMP:  rdata = tim_cmp;
          TIM_CTRL: rdata = tim_ctrl;
          default:  rdata = '0;
        endcase
      end
    end
  end

endmodule
